// File: rtl/mux_pkg.sv
// Shared selector types and named select codes for the registered 4:1 mux.
package mux_pkg;

    // 2-bit selector used by reg_mux4
    typedef logic [1:0] mux4_sel_t;

    // Named select codes, one per data input
    localparam mux4_sel_t SEL_IN0 = 2'd0;
    localparam mux4_sel_t SEL_IN1 = 2'd1;
    localparam mux4_sel_t SEL_IN2 = 2'd2;
    localparam mux4_sel_t SEL_IN3 = 2'd3;

endpackage : mux_pkg

// File: rtl/mux2.sv
// Purely combinational N-bit 2:1 word multiplexer, leaf cell of the reg_mux4 tree.
// Ports:
//   in0    - word chosen when select = 0
//   in1    - word chosen when select = 1
//   select - 1-bit selector
//   out    - selected word (combinational)
module mux2 #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic         select,
    output logic [N-1:0] out
);

    // Default arm covers 0 and any X/Z on select, so no latch is inferred
    always_comb begin
        out = in0;
        case (select)
            1'b1:    out = in1;
            default: out = in0;
        endcase
    end

endmodule : mux2

// File: rtl/reg_mux4.sv
// Parameterised 4:1 word multiplexer with a registered output stage.
// A two-level tree of mux2 cells forms the pre-selected word, which is
// captured into the output register on enabled clock edges.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset (priority over en)
//   in0..in3  - N-bit data words, chosen by select = 0..3
//   select    - 2-bit input selector
//   en        - output register load enable
//   out       - registered selected word
//   out_valid - set once a capture with en = 1 has happened since reset
module reg_mux4
    import mux_pkg::*;
#(
    parameter int unsigned    N           = 4,
    parameter logic [N-1:0]   RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    input  mux4_sel_t    select,
    input  logic         en,
    output logic [N-1:0] out,
    output logic         out_valid
);

    logic [N-1:0] lo_word;      // in0/in1 pick by select[0]
    logic [N-1:0] hi_word;      // in2/in3 pick by select[0]
    logic [N-1:0] sel_word;     // final pick by select[1]

    logic [N-1:0] out_d,       out_q;
    logic         out_valid_d, out_valid_q;

    // Level 1 of the selection tree
    mux2 #(.N(N)) u_lvl1_lo (
        .in0    (in0),
        .in1    (in1),
        .select (select[0]),
        .out    (lo_word)
    );

    mux2 #(.N(N)) u_lvl1_hi (
        .in0    (in2),
        .in1    (in3),
        .select (select[0]),
        .out    (hi_word)
    );

    // Level 2 of the selection tree
    mux2 #(.N(N)) u_lvl2 (
        .in0    (lo_word),
        .in1    (hi_word),
        .select (select[1]),
        .out    (sel_word)
    );

    // Next-state: hold unless enabled, then capture the pre-selected word
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_d       = sel_word;
            out_valid_d = 1'b1;
        end
    end

    // Output register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= RESET_VALUE;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule : reg_mux4

// File: tb/tb_reg_mux4.sv
// Self-checking bench for reg_mux4: a vector table on a 4-bit instance plus
// hand-written sequences on an 8-bit instance with a non-zero reset value.
module tb_reg_mux4;
    import mux_pkg::*;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit instance, default reset value
    logic       rst_a, en_a;
    logic [3:0] a0, a1, a2, a3, out_a;
    mux4_sel_t  sel_a;
    logic       valid_a;

    reg_mux4 #(.N(4)) dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .in0       (a0),
        .in1       (a1),
        .in2       (a2),
        .in3       (a3),
        .select    (sel_a),
        .en        (en_a),
        .out       (out_a),
        .out_valid (valid_a)
    );

    // 8-bit instance, reset value 8'h3C
    logic       rst_b, en_b;
    logic [7:0] b0, b1, b2, b3, out_b;
    mux4_sel_t  sel_b;
    logic       valid_b;

    reg_mux4 #(.N(8), .RESET_VALUE(8'h3C)) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .in0       (b0),
        .in1       (b1),
        .in2       (b2),
        .in3       (b3),
        .select    (sel_b),
        .en        (en_b),
        .out       (out_b),
        .out_valid (valid_b)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        mux4_sel_t  sel;
        logic [3:0] i0, i1, i2, i3;
        logic [3:0] exp_out;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(string name, logic rst, logic en, mux4_sel_t sel,
                                logic [3:0] i0, logic [3:0] i1, logic [3:0] i2,
                                logic [3:0] i3, logic [3:0] eo, logic ev);
        vec_t v;
        v.name = name; v.rst = rst; v.en = en; v.sel = sel;
        v.i0 = i0; v.i1 = i1; v.i2 = i2; v.i3 = i3;
        v.exp_out = eo; v.exp_valid = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b1; sel_a = SEL_IN0;
        a0 = 4'd1; a1 = 4'd2; a2 = 4'd3; a3 = 4'd4;
        rst_b = 1'b1; en_b = 1'b1; sel_b = SEL_IN0;
        b0 = 8'hA5; b1 = 8'h5A; b2 = 8'hFF; b3 = 8'h00;

        // Expected values are out/out_valid right after the edge the row is applied to
        vecs.push_back(mk("rst1",      1, 1, SEL_IN0, 1, 2, 3, 4, 4'd0, 0));
        vecs.push_back(mk("rst2",      1, 1, SEL_IN0, 1, 2, 3, 4, 4'd0, 0));
        vecs.push_back(mk("sweep0",    0, 1, SEL_IN0, 1, 2, 3, 4, 4'd1, 1));
        vecs.push_back(mk("sweep1",    0, 1, SEL_IN1, 1, 2, 3, 4, 4'd2, 1));
        vecs.push_back(mk("sweep2",    0, 1, SEL_IN2, 1, 2, 3, 4, 4'd3, 1));
        vecs.push_back(mk("sweep3",    0, 1, SEL_IN3, 1, 2, 3, 4, 4'd4, 1));
        vecs.push_back(mk("midrst",    1, 1, SEL_IN2, 1, 2, 3, 4, 4'd0, 0));
        vecs.push_back(mk("release",   0, 1, SEL_IN3, 1, 2, 3, 4, 4'd4, 1));
        vecs.push_back(mk("hold_cap",  0, 1, SEL_IN1, 1, 2, 3, 4, 4'd2, 1));
        vecs.push_back(mk("hold_en0",  0, 0, SEL_IN3, 1, 7, 3, 4, 4'd2, 1));
        vecs.push_back(mk("hold_en0b", 0, 0, SEL_IN1, 1, 7, 3, 4, 4'd2, 1));
        vecs.push_back(mk("hold_reen", 0, 1, SEL_IN3, 1, 7, 3, 4, 4'd4, 1));
        vecs.push_back(mk("track1",    0, 1, SEL_IN0, 1, 7, 3, 4, 4'd1, 1));
        vecs.push_back(mk("track9",    0, 1, SEL_IN0, 9, 7, 3, 4, 4'd9, 1));
        vecs.push_back(mk("track6",    0, 1, SEL_IN0, 6, 7, 3, 4, 4'd6, 1));
        vecs.push_back(mk("rst_pri",   1, 0, SEL_IN1, 6, 7, 3, 4, 4'd0, 0));
        vecs.push_back(mk("en0_norst", 0, 0, SEL_IN1, 6, 7, 3, 4, 4'd0, 0));
        vecs.push_back(mk("first_cap", 0, 1, SEL_IN2, 6, 7, 3, 4, 4'd3, 1));

        foreach (vecs[k]) begin
            rst_a = vecs[k].rst; en_a = vecs[k].en; sel_a = vecs[k].sel;
            a0 = vecs[k].i0; a1 = vecs[k].i1; a2 = vecs[k].i2; a3 = vecs[k].i3;
            @(posedge clk);
            #1;
            chk({vecs[k].name, ".out"},   8'(out_a),   8'(vecs[k].exp_out));
            chk({vecs[k].name, ".valid"}, 8'(valid_a), 8'(vecs[k].exp_valid));
        end

        // 8-bit instance: non-zero reset value, full-width data, latency
        @(posedge clk); #1;
        chk("b_rst.out",   out_b,          8'h3C);
        chk("b_rst.valid", 8'(valid_b),    8'h00);

        rst_b = 1'b0; sel_b = SEL_IN3;
        @(posedge clk); #1;
        chk("b_sel3.out",   out_b,       8'h00);
        chk("b_sel3.valid", 8'(valid_b), 8'h01);

        sel_b = SEL_IN2;
        @(posedge clk); #1;
        chk("b_sel2.out", out_b, 8'hFF);

        // New select must not reach out before the next edge
        sel_b = SEL_IN1;
        #2;
        chk("b_nocomb.out", out_b, 8'hFF);
        @(posedge clk); #1;
        chk("b_sel1.out", out_b, 8'h5A);

        // Select and data change together: value sampled at the edge wins
        sel_b = SEL_IN0; b0 = 8'hC3;
        @(posedge clk); #1;
        chk("b_simul.out", out_b, 8'hC3);

        // Reset with en low still returns to the reset value
        rst_b = 1'b1; en_b = 1'b0;
        @(posedge clk); #1;
        chk("b_rst_en0.out",   out_b,       8'h3C);
        chk("b_rst_en0.valid", 8'(valid_b), 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_reg_mux4
